// File: rtl/rv32m_divider_pkg.sv
// Shared RV32M divider definitions: op encodings, FSM states, constants and
// the conditional two's-complement negate used for magnitudes and fixups.
package rv32m_divider_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // 0x80000000 negates to itself, which is exactly the unsigned magnitude.
  function automatic logic [31:0] cond_neg(input logic [31:0] value, input logic en);
    logic [31:0] res;
    if (en) begin
      res = ~value + 32'h0000_0001;
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32m_divider_if.sv
// Request/response bundle between the EX stage and the iterative divider.
interface rv32m_divider_if #(
  parameter int XLEN = 32
) ();

  logic            start;
  logic            kill;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, kill, op, dividend, divisor,
    input  busy, done, result
  );

  modport slave (
    input  start, kill, op, dividend, divisor,
    output busy, done, result
  );

endinterface

// File: rtl/rv32m_divider_div_trial_sub.sv
// 33-bit trial subtractor for the restoring divider; neg is the borrow.
// Kept standalone so a faster adder can be dropped in later.
module div_trial_sub (
  input  logic [32:0] a,
  input  logic [32:0] b,
  output logic [31:0] diff,
  output logic        neg
);

  logic [32:0] full_s;

  // Full-width difference; bit 32 set means the trial went negative.
  always_comb begin
    full_s = a - b;
    diff   = full_s[31:0];
    neg    = full_s[32];
  end

endmodule

// File: rtl/rv32m_divider.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU: one quotient
// bit per cycle, sign and special-case fixups in a final cycle.
module rv32m_divider
  import rv32m_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst,
  rv32m_divider_if.slave  bus
);

  state_t          state_r;
  logic            rem_sel_r;
  logic            dvd_neg_r;
  logic            dvs_neg_r;
  logic [XLEN-1:0] dvs_mag_r;
  logic [XLEN-1:0] q_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      count_r;
  logic            busy_r;
  logic            done_r;

  logic            is_signed_s;
  logic            dvd_neg_s;
  logic            dvs_neg_s;
  logic            special_s;
  logic [XLEN-1:0] dvd_mag_s;
  logic [XLEN-1:0] dvs_mag_s;
  logic [XLEN-1:0] special_res_s;
  logic [XLEN:0]   partial_s;
  logic [XLEN-1:0] diff_s;
  logic            neg_s;
  logic [XLEN-1:0] quo_fix_s;
  logic [XLEN-1:0] rem_fix_s;

  // Request decode: magnitudes, signs and the two early-exit cases.
  always_comb begin
    is_signed_s = (bus.op == OP_DIV) || (bus.op == OP_REM);
    dvd_neg_s   = is_signed_s & bus.dividend[31];
    dvs_neg_s   = is_signed_s & bus.divisor[31];
    dvd_mag_s   = cond_neg(bus.dividend, dvd_neg_s);
    dvs_mag_s   = cond_neg(bus.divisor, dvs_neg_s);
    if (bus.divisor == 32'h0000_0000) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? bus.dividend : ALL_ONES;
    end else if (is_signed_s && (bus.dividend == INT_MIN) && (bus.divisor == ALL_ONES)) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? 32'h0000_0000 : INT_MIN;
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'h0000_0000;
    end
  end

  // Shift in the next dividend bit; the quotient register feeds it from its MSB.
  always_comb begin
    partial_s = {rem_r, q_r[XLEN-1]};
    quo_fix_s = cond_neg(q_r, dvd_neg_r ^ dvs_neg_r);
    rem_fix_s = cond_neg(rem_r, dvd_neg_r);
  end

  div_trial_sub u_trial_sub (
    .a    (partial_s),
    .b    ({1'b0, dvs_mag_r}),
    .diff (diff_s),
    .neg  (neg_s)
  );

  // Divider FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rem_sel_r <= 1'b0;
      dvd_neg_r <= 1'b0;
      dvs_neg_r <= 1'b0;
      dvs_mag_r <= 32'h0000_0000;
      q_r       <= 32'h0000_0000;
      rem_r     <= 32'h0000_0000;
      result_r  <= 32'h0000_0000;
      count_r   <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else if (bus.kill) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            rem_sel_r <= bus.op[1];
            dvd_neg_r <= dvd_neg_s;
            dvs_neg_r <= dvs_neg_s;
            dvs_mag_r <= dvs_mag_s;
            q_r       <= dvd_mag_s;
            rem_r     <= 32'h0000_0000;
            count_r   <= 5'd0;
            busy_r    <= 1'b1;
            if (special_s) begin
              result_r <= special_res_s;
              done_r   <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              done_r   <= 1'b0;
              state_r  <= ST_CALC;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        ST_CALC: begin
          q_r     <= {q_r[XLEN-2:0], ~neg_s};
          rem_r   <= neg_s ? partial_s[XLEN-1:0] : diff_s;
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_CALC;
          end
        end
        ST_FIX: begin
          result_r <= rem_sel_r ? rem_fix_s : quo_fix_s;
          done_r   <= 1'b1;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_rv32m_divider.sv
// Directed bench for rv32m_divider: a transaction-level model checked every
// cycle, plus hand-computed results and done-cycle numbers.
module tb_rv32m_divider;
  import rv32m_divider_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32m_divider_if #(.XLEN(32)) bus ();

  rv32m_divider #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit stim_done = 1'b0;

  // Model: cycles left until idle (34 normal, 1 special) and the architectural result.
  int          m_left = 0;
  logic [31:0] m_result = 32'h0;
  logic [31:0] m_pend = 32'h0;

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (sgn) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == OP_DIV) || (op == OP_REM);
    return (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left   <= 0;
      m_result <= 32'h0;
    end else if (bus.kill) begin
      m_left <= 0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_pend <= ref_div(bus.op, bus.dividend, bus.divisor);
        if (is_special(bus.op, bus.dividend, bus.divisor)) begin
          m_left   <= 1;
          m_result <= ref_div(bus.op, bus.dividend, bus.divisor);
        end else begin
          m_left <= 34;
        end
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_result <= m_pend;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request in the current cycle (cycle 0); returns in cycle 1.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op = o;
    bus.dividend = a;
    bus.divisor = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_c1", {31'b0, bus.busy}, 32'h1);
  endtask

  // From cycle 1, waits (bounded) for done; checks its cycle and result, then steps past DONE.
  task automatic wait_done(input string name, input logic [31:0] exp, input int exp_cyc);
    int cyc;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 60) begin
      tick();
      cyc++;
    end
    chk({name, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk(name, bus.result, exp);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.op = 2'b00;
    bus.dividend = 32'h0;
    bus.divisor = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    fork
      begin
        while (!stim_done) begin
          @(negedge clk);
          if (chk_en && !stim_done) begin
            chk("mon_busy", {31'b0, bus.busy}, {31'b0, m_left != 0});
            chk("mon_done", {31'b0, bus.done}, {31'b0, m_left == 1});
            chk("mon_result", bus.result, m_result);
          end
        end
      end
      begin
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        chk("reset_done", {31'b0, bus.done}, 32'h0);
        chk("reset_result", bus.result, 32'h0);

        chk("model_div_neg", ref_div(OP_DIV, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFD);
        chk("model_rem_neg", ref_div(OP_REM, 32'hFFFF_FFF9, 32'h2), 32'hFFFF_FFFF);
        chk("model_rem_ovf", ref_div(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF), 32'h0);

        start_op(OP_DIVU, 32'd100, 32'd7);                wait_done("divu_100_7", 32'd14, 34);
        start_op(OP_REMU, 32'd100, 32'd7);                wait_done("remu_100_7", 32'd2, 34);
        start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);           wait_done("div_m7_2", 32'hFFFF_FFFD, 34);
        start_op(OP_REM, 32'hFFFF_FFF9, 32'd2);           wait_done("rem_m7_2", 32'hFFFF_FFFF, 34);
        start_op(OP_REM, 32'd7, 32'hFFFF_FFFE);           wait_done("rem_7_m2", 32'd1, 34);
        start_op(OP_DIVU, 32'h1234, 32'h0);               wait_done("divu_by0", 32'hFFFF_FFFF, 1);
        start_op(OP_REM, 32'h1234, 32'h0);                wait_done("rem_by0", 32'h1234, 1);
        start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("div_ovf", 32'h8000_0000, 1);
        start_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("rem_ovf", 32'h0, 1);
        start_op(OP_REMU, 32'hFFFF_FFFF, 32'd10);         wait_done("remu_max_10", 32'd5, 34);
        start_op(OP_DIV, 32'h8000_0000, 32'd2);           wait_done("div_intmin_2", 32'hC000_0000, 34);

        // kill in cycle 10, restart in cycle 11 finishing in cycle 45
        start_op(OP_DIVU, 32'd100, 32'd7);
        repeat (9) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        chk("kill_busy", {31'b0, bus.busy}, 32'h0);
        chk("kill_done", {31'b0, bus.done}, 32'h0);
        chk("kill_result", bus.result, 32'hC000_0000);
        start_op(OP_DIVU, 32'd100, 32'd7);                wait_done("after_kill", 32'd14, 34);

        // kill together with start in IDLE is not accepted
        bus.op = OP_DIVU; bus.dividend = 32'd9; bus.divisor = 32'd3;
        bus.kill = 1'b1; bus.start = 1'b1;
        tick();
        bus.kill = 1'b0; bus.start = 1'b0;
        chk("kill_start_busy", {31'b0, bus.busy}, 32'h0);

        // start pulses in cycles 5 and 34 are ignored
        start_op(OP_DIVU, 32'd1000, 32'd10);
        repeat (4) tick();
        bus.op = OP_REMU; bus.dividend = 32'd5; bus.divisor = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (28) tick();
        chk("ign_done_c34", {31'b0, bus.done}, 32'h1);
        chk("ign_result_c34", bus.result, 32'd100);
        bus.op = OP_DIVU; bus.dividend = 32'd9; bus.divisor = 32'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ign_busy_c35", {31'b0, bus.busy}, 32'h0);
        chk("ign_result_c35", bus.result, 32'd100);

        // reset in cycle 20 clears everything by cycle 21
        start_op(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_done", {31'b0, bus.done}, 32'h0);
        chk("rst_result", bus.result, 32'h0);
        start_op(OP_DIV, 32'd20, 32'hFFFF_FFFD);          wait_done("div_20_m3", 32'hFFFF_FFFA, 34);

        stim_done = 1'b1;
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
